// File: rtl/frame_pkg.sv
// Shared timing defaults, address-width helper and the registered scan-output record
// for the 1-bit VGA frame buffer.
package frame_pkg;

    function automatic int addr_w(input int ha, input int va);
        return (ha * va > 1) ? $clog2(ha * va) : 1;
    endfunction

    localparam int DEF_HOR_ACTIVE  = 640;
    localparam int DEF_VER_ACTIVE  = 480;
    localparam int DEF_HOR_FP      = 16;
    localparam int DEF_HOR_SYNC    = 96;
    localparam int DEF_HOR_BP      = 48;
    localparam int DEF_VER_FP      = 10;
    localparam int DEF_VER_SYNC    = 2;
    localparam int DEF_VER_BP      = 33;
    localparam int DEF_ADDR_W      = addr_w(DEF_HOR_ACTIVE, DEF_VER_ACTIVE);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } scan_t;

    localparam scan_t SCAN_RST = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

endpackage

// File: rtl/frame_buffer_if.sv
// Renderer/display-facing bundle of the frame buffer: pixel-rate enable, write port,
// swap strobe and the scan outputs.
interface frame_buffer_if
    import frame_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              ce;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              swap;
    logic              hsync;
    logic              vsync;
    logic              pixel;

    modport master (
        output ce, wr_en, wr_addr, wr_data,
        input  swap, hsync, vsync, pixel
    );

    modport slave (
        input  ce, wr_en, wr_addr, wr_data,
        output swap, hsync, vsync, pixel
    );
endinterface

// File: rtl/frame_buffer_bit_ram.sv
// Simple dual-port 1-bit RAM: synchronous write, registered read that only updates
// when rd_en is high.
module bit_ram
    import frame_pkg::*;
#(
    parameter int DEPTH  = DEF_HOR_ACTIVE * DEF_VER_ACTIVE,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data
);
    logic mem [0:DEPTH-1];
    logic rd_data_q;
    logic rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/frame_buffer.sv
// 1-bit VGA scanout with renderer write port. Define FRAME_BUFFER_DOUBLE_BUFFER_EN for
// front/back buffering; otherwise a single buffer is read and written directly.
module frame_buffer
    import frame_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE,
    parameter int VER_ACTIVE_PIXELS = DEF_VER_ACTIVE,
    parameter int HOR_FRONT_PORCH   = DEF_HOR_FP,
    parameter int HOR_SYNC          = DEF_HOR_SYNC,
    parameter int HOR_BACK_PORCH    = DEF_HOR_BP,
    parameter int VER_FRONT_PORCH   = DEF_VER_FP,
    parameter int VER_SYNC          = DEF_VER_SYNC,
    parameter int VER_BACK_PORCH    = DEF_VER_BP
) (
    input logic           clk,
    input logic           rst,
    frame_buffer_if.slave bus
);
    localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
    localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int DEPTH   = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int ADDR_W  = addr_w(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);

    localparam logic [HW-1:0]   H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]   H_ACT    = HW'(HOR_ACTIVE_PIXELS);
    localparam logic [HW-1:0]   HS_BEG   = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [HW-1:0]   HS_END   = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC);
    localparam logic [VW-1:0]   V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]   V_ACT    = VW'(VER_ACTIVE_PIXELS);
    localparam logic [VW-1:0]   VS_BEG   = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [VW-1:0]   VS_END   = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    scan_t             out_q, out_d;

    logic h_wrap, v_wrap, active, swap_hit, wr_ok, rd_en, rd_bit;

    assign h_wrap   = (h_q == H_LAST);
    assign v_wrap   = (v_q == V_LAST);
    assign active   = (h_q < H_ACT) && (v_q < V_ACT);
    assign swap_hit = bus.ce && (h_q == '0) && (v_q == V_ACT);
    assign wr_ok    = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_C);
    assign rd_en    = bus.ce && active;

    // Outputs register the state of the current position, so they lag the counters by one ce.
    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        rd_addr_d = rd_addr_q;
        out_d     = out_q;
        if (bus.ce) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
            if (h_wrap && v_wrap)
                rd_addr_d = '0;
            else if (active)
                rd_addr_d = rd_addr_q + 1'b1;
            out_d.hsync  = !((h_q >= HS_BEG) && (h_q < HS_END));
            out_d.vsync  = !((v_q >= VS_BEG) && (v_q < VS_END));
            out_d.active = active;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q       <= '0;
            v_q       <= '0;
            rd_addr_q <= '0;
            out_q     <= SCAN_RST;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            rd_addr_q <= rd_addr_d;
            out_q     <= out_d;
        end
    end

`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
    logic front_q, front_d;
    logic rd_data0, rd_data1;

    always_comb begin
        front_d = front_q;
        if (swap_hit) front_d = !front_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) front_q <= 1'b0;
        else     front_q <= front_d;
    end

    // Writes use the pre-toggle front, so a write on the swap cycle lands in the buffer about to be shown.
    bit_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram0 (
        .clk     (clk),
        .wr_en   (wr_ok && front_q),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data0)
    );

    bit_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram1 (
        .clk     (clk),
        .wr_en   (wr_ok && !front_q),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data1)
    );

    assign rd_bit = front_q ? rd_data1 : rd_data0;
`else
    bit_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram0 (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (rd_bit)
    );
`endif

    assign bus.swap  = swap_hit;
    assign bus.hsync = out_q.hsync;
    assign bus.vsync = out_q.vsync;
    assign bus.pixel = out_q.active && rd_bit;
endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer on a shrunken 8x6 raster (15x11 total) so whole frames stay short.
module tb_frame_buffer;
    localparam int HA = 8, VA = 6, HFP = 2, HS = 3, HBP = 2, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_buffer_if #(.ADDR_W(AW)) bus ();

    frame_buffer #(
        .HOR_ACTIVE_PIXELS (HA), .VER_ACTIVE_PIXELS (VA),
        .HOR_FRONT_PORCH   (HFP), .HOR_SYNC (HS), .HOR_BACK_PORCH (HBP),
        .VER_FRONT_PORCH   (VFP), .VER_SYNC (VS), .VER_BACK_PORCH (VBP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0, errors = 0;
    int mh = 0, mv = 0;
    bit front_m = 1'b0;
    bit buf_m [2][HA*VA];
    int sw_clks = 0, sw_pulses = 0;
    bit sw_prev = 1'b0;
    int hs_low, vs_low, hs_fall, px_ones;
    bit hs_prev;

    always @(negedge clk) begin
        if (bus.swap === 1'b1) begin
            sw_clks++;
            if (!sw_prev) sw_pulses++;
        end
        sw_prev = (bus.swap === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wbuf();
`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
        return front_m ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    task automatic model_write(input logic [AW-1:0] wa, input bit wd);
        if (int'(wa) < HA * VA) buf_m[wbuf()][int'(wa)] = wd;
    endtask

    task automatic wr(input logic [AW-1:0] wa, input bit wd);
        bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        model_write(wa, wd);
    endtask

    // One ce step: ce high for one clk, then per-1 idle clks.
    task automatic step(input int per, input bit we, input logic [AW-1:0] wa, input bit wd);
        bit e_sw, e_hs, e_vs, e_px;
        e_sw = (mh == 0 && mv == VA);
        e_hs = !(mh >= HA + HFP && mh < HA + HFP + HS);
        e_vs = !(mv >= VA + VFP && mv < VA + VFP + VS);
        e_px = (mh < HA && mv < VA) ? buf_m[front_m][mv * HA + mh] : 1'b0;
        bus.ce = 1'b1; bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        @(negedge clk);
        chk("swap_on_ce", bus.swap, e_sw);
        if (we) model_write(wa, wd);
`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
        if (e_sw) front_m = !front_m;
`endif
        @(posedge clk); #1;
        bus.ce = 1'b0; bus.wr_en = 1'b0;
        chk("hsync", bus.hsync, e_hs);
        chk("vsync", bus.vsync, e_vs);
        chk("pixel", bus.pixel, e_px);
        if (!bus.hsync) hs_low++;
        if (!bus.vsync) vs_low++;
        if (hs_prev && !bus.hsync) hs_fall++;
        if (bus.pixel) px_ones++;
        hs_prev = bus.hsync;
        for (int i = 1; i < per; i++) begin
            @(negedge clk);
            chk("swap_ce_low", bus.swap, 1'b0);
            chk("hold_hsync", bus.hsync, e_hs);
            chk("hold_vsync", bus.vsync, e_vs);
            chk("hold_pixel", bus.pixel, e_px);
            @(posedge clk); #1;
        end
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
    endtask

    task automatic run_frame(input int per, input bit swap_wr, input int exp_ones);
        hs_low = 0; vs_low = 0; hs_fall = 0; px_ones = 0; hs_prev = 1'b1;
        for (int k = 0; k < HT * VT; k++)
            step(per, swap_wr && mh == 0 && mv == VA, 6'd5, 1'b1);
        chk("hsync_low_ce_per_frame", hs_low, 33);
        chk("vsync_low_ce_per_frame", vs_low, 30);
        chk("lines_per_frame", hs_fall, 11);
        chk("lit_pixels_per_frame", px_ones, exp_ones);
    endtask

    initial begin
        rst = 1'b1;
        bus.ce = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 1'b0;
        #12;
        chk("rst_hsync", bus.hsync, 1'b1);
        chk("rst_vsync", bus.vsync, 1'b1);
        chk("rst_pixel", bus.pixel, 1'b0);
        chk("rst_swap",  bus.swap,  1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        wr(6'd0,  1'b1);
        wr(6'd47, 1'b1);
        wr(6'd48, 1'b1);

`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
        run_frame(1, 1'b0, 0);
        run_frame(1, 1'b1, 2);
        run_frame(1, 1'b0, 1);
`else
        run_frame(1, 1'b0, 2);
        run_frame(1, 1'b1, 2);
        run_frame(1, 1'b0, 3);
`endif
        chk("swap_pulses_3_frames", sw_pulses, 3);
        chk("swap_clks_3_frames",   sw_clks,   3);

`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
        run_frame(4, 1'b0, 2);
`else
        run_frame(4, 1'b0, 3);
`endif
        chk("swap_pulses_ce_div4", sw_pulses, 4);
        chk("swap_clks_ce_div4",   sw_clks,   4);

        while (!(mh == 11 && mv == 7)) step(1, 1'b0, '0, 1'b0);
        chk("pre_rst_hsync", bus.hsync, 1'b0);
        chk("pre_rst_vsync", bus.vsync, 1'b0);
        bus.ce = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_hsync", bus.hsync, 1'b1);
        chk("mid_rst_vsync", bus.vsync, 1'b1);
        chk("mid_rst_pixel", bus.pixel, 1'b0);
        chk("mid_rst_swap",  bus.swap,  1'b0);
        bus.ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mh = 0; mv = 0; front_m = 1'b0;

`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
        run_frame(1, 1'b0, 1);
`else
        run_frame(1, 1'b0, 3);
`endif
        chk("swap_pulses_total", sw_pulses, 6);
        chk("swap_clks_total",   sw_clks,   6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
